io_port_sched: RTL

Round-robin scheduler for the 8-bit I/O subsystem: arbitrates four input devices onto the single 4:1 input byte mux. It handshakes each device with a req/ack pair, presents the granted byte to the CPU datapath and drops stale bytes after a programmable timeout. It also sequences CPU writes into the four output registers by generating the decoder select, load-enable and source-select (register vs immediate) one cycle after a CPU write command. It sits between the control unit and the input-mux/output-register block.

---
 rtl/io_port_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/io_port_sched.sv
// Round-robin input-device scheduler with timeout drop, plus the one-cycle
// delayed output-register write sequencer for the 8-bit I/O subsystem.
module io_port_sched #(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] ack,
    output logic [1:0] in_sel,
    output logic       in_valid,
    input  logic       cpu_rd,
    output logic [3:0] drop,
    input  logic       clr_drop,
    input  logic       cpu_wr,
    input  logic [1:0] wr_port,
    input  logic       wr_src,
    output logic [1:0] out_sel,
    output logic       out_we,
    output logic       out_src
);

    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = LAST[CW-1:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t        state_r;
    logic [1:0]    ptr_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    grant_s;
    logic          timeout_hit_s;
    logic [3:0]    drop_set_s;

    // First requesting device after ptr, wrapping so ptr itself is tried last.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = p;
        for (int i = 3; i >= 0; i--) begin
            idx = p + 2'd1 + i[1:0];
            if (r[idx]) begin
                pick = idx;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

    // Grant candidate and timeout detection for the presented byte.
    always_comb begin
        grant_s       = rr_pick(req, ptr_r);
        timeout_hit_s = (TIMEOUT != 0) && (cnt_r == CNT_LAST);
        drop_set_s    = 4'b0000;
        if ((state_r == PRESENT) && !cpu_rd && timeout_hit_s) begin
            drop_set_s = onehot(in_sel);
        end else begin
            drop_set_s = 4'b0000;
        end
    end

    // Input handshake FSM: grant, present, acknowledge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            ptr_r    <= 2'd3;
            cnt_r    <= '0;
            ack      <= 4'b0000;
            in_sel   <= 2'd0;
            in_valid <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack <= 4'b0000;
                    if (|req) begin
                        in_sel   <= grant_s;
                        in_valid <= 1'b1;
                        cnt_r    <= '0;
                        state_r  <= PRESENT;
                    end
                end
                PRESENT: begin
                    // A read on the timeout cycle takes precedence over the drop.
                    if (cpu_rd || timeout_hit_s) begin
                        ack      <= onehot(in_sel);
                        in_valid <= 1'b0;
                        state_r  <= ACK;
                    end else if (cnt_r != {CW{1'b1}}) begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ACK: begin
                    ack     <= 4'b0000;
                    ptr_r   <= in_sel;
                    state_r <= IDLE;
                end
                default: begin
                    ack      <= 4'b0000;
                    in_valid <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    // Sticky drop flags; a fresh drop survives a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            drop <= 4'b0000;
        end else begin
            drop <= (clr_drop ? 4'b0000 : drop) | drop_set_s;
        end
    end

    // Output register write sequencing, one cycle behind the CPU command.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_we  <= 1'b0;
            out_sel <= 2'd0;
            out_src <= 1'b0;
        end else begin
            out_we <= cpu_wr;
            if (cpu_wr) begin
                out_sel <= wr_port;
                out_src <= wr_src;
            end
        end
    end

endmodule
